// File: rtl/legv8_ctrl_pkg.sv
// Shared definitions for the LEGv8 multi-cycle control: state encodings,
// opcode patterns and the select codes seen by the ALU control stage.
package legv8_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_WB_LOAD  = 4'd4,
    S_MEM_WR   = 4'd5,
    S_EXEC_R   = 4'd6,
    S_WB_R     = 4'd7,
    S_BR_CBZ   = 4'd8,
    S_BR_B     = 4'd9,
    S_HALT     = 4'd10
  } state_t;

  // Opcode values; don't-care bits are zero here and cleared by the mask
  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [10:0] OP_CBZ  = 11'b10110100000;
  localparam logic [10:0] OP_B    = 11'b00010100000;

  localparam logic [10:0] MASK_FULL = 11'b11111111111;
  localparam logic [10:0] MASK_CBZ  = 11'b11111111000;
  localparam logic [10:0] MASK_B    = 11'b11111100000;

  // One-hot instruction class bit positions
  localparam int CLS_RTYPE   = 0;
  localparam int CLS_LDUR    = 1;
  localparam int CLS_STUR    = 2;
  localparam int CLS_CBZ     = 3;
  localparam int CLS_B       = 4;
  localparam int CLS_ILLEGAL = 5;
  localparam int CLS_W       = 6;

  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_PASSB = 2'b01;
  localparam logic [1:0] ALU_OP_RTYPE = 2'b10;

  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_DIMM  = 2'b10;
  localparam logic [1:0] SRCB_BROFF = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;

  function automatic logic op_match(logic [10:0] op, logic [10:0] val,
                                    logic [10:0] mask);
    return (op & mask) == val;
  endfunction

endpackage

// File: rtl/legv8_opcode_decode.sv
// Combinational opcode classifier: one-hot class from the 11-bit opcode.
module legv8_opcode_decode
  import legv8_ctrl_pkg::*;
(
  input  logic [10:0]      opcode,
  output logic [CLS_W-1:0] cls
);

  // Match each class pattern; anything unmatched is illegal
  always_comb begin
    cls = '0;
    cls[CLS_RTYPE] = op_match(opcode, OP_ADD, MASK_FULL) |
                     op_match(opcode, OP_SUB, MASK_FULL) |
                     op_match(opcode, OP_AND, MASK_FULL) |
                     op_match(opcode, OP_ORR, MASK_FULL);
    cls[CLS_LDUR]  = op_match(opcode, OP_LDUR, MASK_FULL);
    cls[CLS_STUR]  = op_match(opcode, OP_STUR, MASK_FULL);
    cls[CLS_CBZ]   = op_match(opcode, OP_CBZ, MASK_CBZ);
    cls[CLS_B]     = op_match(opcode, OP_B, MASK_B);
    cls[CLS_ILLEGAL] = ~|cls[CLS_B:CLS_RTYPE];
  end

endmodule

// File: rtl/legv8_multicycle_control.sv
// LEGv8 multi-cycle main control: Moore FSM sequencing fetch/decode/
// execute/memory/write-back, sticky illegal flag and retired counter.
module legv8_multicycle_control
  import legv8_ctrl_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [10:0]      Opcode,
  input  logic             Mem_Ready,
  output logic             PC_Write,
  output logic             PC_WriteCond,
  output logic             IorD,
  output logic             Mem_Read,
  output logic             Mem_Write,
  output logic             IR_Write,
  output logic             Mem_to_Reg,
  output logic             Reg_Write,
  output logic             ALU_SrcA,
  output logic             Reg2Loc,
  output logic [1:0]       ALU_SrcB,
  output logic [1:0]       ALU_Op,
  output logic [1:0]       PC_Source,
  output logic             Illegal,
  output logic [3:0]       State,
  output logic [CNT_W-1:0] Retired
);

  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  state_t           state, state_next;
  logic [CLS_W-1:0] cls;
  logic             is_stur_q;
  logic             illegal_q;
  logic [CNT_W-1:0] retired_q;
  logic             retire;

  legv8_opcode_decode u_decode (
    .opcode (Opcode),
    .cls    (cls)
  );

  // State, latched load/store class, sticky illegal flag and counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_FETCH;
      is_stur_q <= 1'b0;
      illegal_q <= 1'b0;
      retired_q <= '0;
    end else begin
      state <= state_next;
      if (state == S_DECODE) is_stur_q <= cls[CLS_STUR];
      if (state_next == S_HALT) illegal_q <= 1'b1;
      if (retire) retired_q <= retired_q + CNT_ONE;
    end
  end

  // Next state and Moore outputs; everything forced low while in reset
  always_comb begin
    state_next   = state;
    retire       = 1'b0;
    PC_Write     = 1'b0;
    PC_WriteCond = 1'b0;
    IorD         = 1'b0;
    Mem_Read     = 1'b0;
    Mem_Write    = 1'b0;
    IR_Write     = 1'b0;
    Mem_to_Reg   = 1'b0;
    Reg_Write    = 1'b0;
    ALU_SrcA     = 1'b0;
    Reg2Loc      = 1'b0;
    ALU_SrcB     = SRCB_REG;
    ALU_Op       = ALU_OP_ADD;
    PC_Source    = PCSRC_ALU;
    case (state)
      S_FETCH: begin
        Mem_Read = 1'b1;
        ALU_SrcB = SRCB_FOUR;
        IR_Write = Mem_Ready;
        PC_Write = Mem_Ready;
        if (Mem_Ready) state_next = S_DECODE;
      end
      S_DECODE: begin
        ALU_SrcB = SRCB_BROFF;
        Reg2Loc  = cls[CLS_STUR] | cls[CLS_CBZ];
        if (cls[CLS_RTYPE])                     state_next = S_EXEC_R;
        else if (cls[CLS_LDUR] | cls[CLS_STUR]) state_next = S_MEM_ADDR;
        else if (cls[CLS_CBZ])                  state_next = S_BR_CBZ;
        else if (cls[CLS_B])                    state_next = S_BR_B;
        else                                    state_next = S_HALT;
      end
      S_MEM_ADDR: begin
        ALU_SrcA   = 1'b1;
        ALU_SrcB   = SRCB_DIMM;
        state_next = is_stur_q ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        Mem_Read = 1'b1;
        IorD     = 1'b1;
        if (Mem_Ready) state_next = S_WB_LOAD;
      end
      S_WB_LOAD: begin
        Reg_Write  = 1'b1;
        Mem_to_Reg = 1'b1;
        retire     = 1'b1;
        state_next = S_FETCH;
      end
      S_MEM_WR: begin
        Mem_Write = 1'b1;
        IorD      = 1'b1;
        Reg2Loc   = 1'b1;
        if (Mem_Ready) begin
          retire     = 1'b1;
          state_next = S_FETCH;
        end
      end
      S_EXEC_R: begin
        ALU_SrcA   = 1'b1;
        ALU_Op     = ALU_OP_RTYPE;
        state_next = S_WB_R;
      end
      S_WB_R: begin
        Reg_Write  = 1'b1;
        retire     = 1'b1;
        state_next = S_FETCH;
      end
      S_BR_CBZ: begin
        ALU_SrcA     = 1'b1;
        ALU_Op       = ALU_OP_PASSB;
        Reg2Loc      = 1'b1;
        PC_WriteCond = 1'b1;
        PC_Source    = PCSRC_ALUOUT;
        retire       = 1'b1;
        state_next   = S_FETCH;
      end
      S_BR_B: begin
        PC_Write   = 1'b1;
        PC_Source  = PCSRC_ALUOUT;
        retire     = 1'b1;
        state_next = S_FETCH;
      end
      S_HALT:  state_next = S_HALT;
      default: state_next = S_HALT;
    endcase
    if (!rst_n) begin
      PC_Write     = 1'b0;
      PC_WriteCond = 1'b0;
      IorD         = 1'b0;
      Mem_Read     = 1'b0;
      Mem_Write    = 1'b0;
      IR_Write     = 1'b0;
      Mem_to_Reg   = 1'b0;
      Reg_Write    = 1'b0;
      ALU_SrcA     = 1'b0;
      Reg2Loc      = 1'b0;
      ALU_SrcB     = 2'b00;
      ALU_Op       = 2'b00;
      PC_Source    = 2'b00;
    end
  end

  assign State   = state;
  assign Illegal = illegal_q;
  assign Retired = retired_q;

endmodule

// File: tb/tb_legv8_multicycle_control.sv
// Directed bench for legv8_multicycle_control (CNT_W=4 to reach wrap).
module tb_legv8_multicycle_control;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [10:0] Opcode = 11'd0;
  logic        Mem_Ready = 1'b0;
  logic        PC_Write, PC_WriteCond, IorD, Mem_Read, Mem_Write, IR_Write;
  logic        Mem_to_Reg, Reg_Write, ALU_SrcA, Reg2Loc, Illegal;
  logic [1:0]  ALU_SrcB, ALU_Op, PC_Source;
  logic [3:0]  State;
  logic [3:0]  Retired;

  int n_tests = 0;
  int n_fail  = 0;
  logic [3:0] exp_ret = 4'd0;

  // Expected strobe vectors, bit order:
  // PC_Write PC_WriteCond IorD Mem_Read | Mem_Write IR_Write Mem_to_Reg Reg_Write |
  // ALU_SrcA Reg2Loc ALU_SrcB[1:0] | ALU_Op[1:0] PC_Source[1:0]
  localparam logic [15:0] O_FETCH_RDY  = 16'h9410;
  localparam logic [15:0] O_FETCH_WAIT = 16'h1010;
  localparam logic [15:0] O_DECODE     = 16'h0030;
  localparam logic [15:0] O_DECODE_R2L = 16'h0070;
  localparam logic [15:0] O_MEM_ADDR   = 16'h00A0;
  localparam logic [15:0] O_MEM_RD     = 16'h3000;
  localparam logic [15:0] O_WB_LOAD    = 16'h0300;
  localparam logic [15:0] O_MEM_WR     = 16'h2840;
  localparam logic [15:0] O_EXEC_R     = 16'h0088;
  localparam logic [15:0] O_WB_R       = 16'h0100;
  localparam logic [15:0] O_BR_CBZ     = 16'h40C5;
  localparam logic [15:0] O_BR_B       = 16'h8001;
  localparam logic [15:0] O_NONE       = 16'h0000;

  localparam logic [10:0] ADD  = 11'b10001011000;
  localparam logic [10:0] LDUR = 11'b11111000010;
  localparam logic [10:0] STUR = 11'b11111000000;
  localparam logic [10:0] CBZ  = 11'b10110100101;
  localparam logic [10:0] BR   = 11'b00010111111;

  wire [15:0] outs = {PC_Write, PC_WriteCond, IorD, Mem_Read, Mem_Write, IR_Write,
                      Mem_to_Reg, Reg_Write, ALU_SrcA, Reg2Loc, ALU_SrcB, ALU_Op,
                      PC_Source};

  legv8_multicycle_control #(.CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .Opcode(Opcode), .Mem_Ready(Mem_Ready),
    .PC_Write(PC_Write), .PC_WriteCond(PC_WriteCond), .IorD(IorD),
    .Mem_Read(Mem_Read), .Mem_Write(Mem_Write), .IR_Write(IR_Write),
    .Mem_to_Reg(Mem_to_Reg), .Reg_Write(Reg_Write), .ALU_SrcA(ALU_SrcA),
    .Reg2Loc(Reg2Loc), .ALU_SrcB(ALU_SrcB), .ALU_Op(ALU_Op),
    .PC_Source(PC_Source), .Illegal(Illegal), .State(State), .Retired(Retired)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // One clock cycle: drive Mem_Ready, check state/outputs mid-cycle, advance
  task automatic cyc(input string tag, input logic mr, input logic [3:0] st,
                     input logic [15:0] o, input logic ill);
    Mem_Ready = mr;
    #1;
    check({tag, ".state"}, {28'd0, State}, {28'd0, st});
    check({tag, ".outs"}, {16'd0, outs}, {16'd0, o});
    check({tag, ".illegal"}, {31'd0, Illegal}, {31'd0, ill});
    @(negedge clk);
  endtask

  task automatic run_add(input string tag);
    Opcode = ADD;
    cyc({tag, ".fetch"}, 1'b1, 4'd0, O_FETCH_RDY, 1'b0);
    cyc({tag, ".decode"}, 1'b1, 4'd1, O_DECODE, 1'b0);
    cyc({tag, ".exec"}, 1'b1, 4'd6, O_EXEC_R, 1'b0);
    cyc({tag, ".wb"}, 1'b1, 4'd7, O_WB_R, 1'b0);
    exp_ret = exp_ret + 4'd1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst.state", {28'd0, State}, 32'd0);
    check("rst.outs", {16'd0, outs}, 32'd0);
    check("rst.illegal", {31'd0, Illegal}, 32'd0);
    check("rst.retired", {28'd0, Retired}, 32'd0);
    exp_ret = 4'd0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    Mem_Ready = 1'b1;
    #2;
    do_reset();

    // ADD: 0 -> 1 -> 6 -> 7 -> 0, Retired 0 -> 1
    run_add("add");
    #1; check("add.retired", {28'd0, Retired}, {28'd0, exp_ret});

    // LDUR with three not-ready cycles in MEM_RD: 8 cycles total
    Opcode = LDUR;
    cyc("ldur.fetch", 1'b1, 4'd0, O_FETCH_RDY, 1'b0);
    cyc("ldur.decode", 1'b1, 4'd1, O_DECODE, 1'b0);
    cyc("ldur.addr", 1'b1, 4'd2, O_MEM_ADDR, 1'b0);
    for (int i = 0; i < 3; i++) cyc("ldur.wait", 1'b0, 4'd3, O_MEM_RD, 1'b0);
    cyc("ldur.rd", 1'b1, 4'd3, O_MEM_RD, 1'b0);
    cyc("ldur.wb", 1'b1, 4'd4, O_WB_LOAD, 1'b0);
    exp_ret = exp_ret + 4'd1;
    #1; check("ldur.retired", {28'd0, Retired}, {28'd0, exp_ret});

    // STUR: Reg2Loc in DECODE and MEM_WR, single write cycle
    Opcode = STUR;
    cyc("stur.fetch", 1'b1, 4'd0, O_FETCH_RDY, 1'b0);
    cyc("stur.decode", 1'b1, 4'd1, O_DECODE_R2L, 1'b0);
    cyc("stur.addr", 1'b1, 4'd2, O_MEM_ADDR, 1'b0);
    cyc("stur.wr", 1'b1, 4'd5, O_MEM_WR, 1'b0);
    exp_ret = exp_ret + 4'd1;
    #1; check("stur.retired", {28'd0, Retired}, {28'd0, exp_ret});

    // CBZ then B (with one fetch wait ahead of B)
    Opcode = CBZ;
    cyc("cbz.fetch", 1'b1, 4'd0, O_FETCH_RDY, 1'b0);
    cyc("cbz.decode", 1'b1, 4'd1, O_DECODE_R2L, 1'b0);
    cyc("cbz.br", 1'b1, 4'd8, O_BR_CBZ, 1'b0);
    exp_ret = exp_ret + 4'd1;
    Opcode = BR;
    cyc("b.fetchwait", 1'b0, 4'd0, O_FETCH_WAIT, 1'b0);
    cyc("b.fetch", 1'b1, 4'd0, O_FETCH_RDY, 1'b0);
    cyc("b.decode", 1'b1, 4'd1, O_DECODE, 1'b0);
    cyc("b.br", 1'b1, 4'd9, O_BR_B, 1'b0);
    exp_ret = exp_ret + 4'd1;
    #1; check("br.retired", {28'd0, Retired}, {28'd0, exp_ret});

    // Illegal opcode: HALT, strobes low for 20 cycles, then reset recovers
    Opcode = 11'd0;
    cyc("ill.fetch", 1'b1, 4'd0, O_FETCH_RDY, 1'b0);
    cyc("ill.decode", 1'b1, 4'd1, O_DECODE, 1'b0);
    for (int i = 0; i < 20; i++) cyc("ill.halt", 1'b1, 4'd10, O_NONE, 1'b1);
    #1; check("ill.retired", {28'd0, Retired}, {28'd0, exp_ret});
    do_reset();
    cyc("ill.recover", 1'b1, 4'd0, O_FETCH_RDY, 1'b0);
    do_reset();

    // 16 ADDs with a 4-bit counter: 15 then wrap to 0
    for (int i = 0; i < 15; i++) run_add("wrap");
    #1; check("wrap.at15", {28'd0, Retired}, 32'd15);
    run_add("wrap");
    #1; check("wrap.at0", {28'd0, Retired}, 32'd0);

    // Reset falling mid-MEM_WR drops Mem_Write without a clock edge
    Opcode = STUR;
    cyc("rstwr.fetch", 1'b1, 4'd0, O_FETCH_RDY, 1'b0);
    cyc("rstwr.decode", 1'b1, 4'd1, O_DECODE_R2L, 1'b0);
    cyc("rstwr.addr", 1'b1, 4'd2, O_MEM_ADDR, 1'b0);
    Mem_Ready = 1'b0;
    #1; check("rstwr.pre", {31'd0, Mem_Write}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("rstwr.memwrite", {31'd0, Mem_Write}, 32'd0);
    check("rstwr.state", {28'd0, State}, 32'd0);
    check("rstwr.retired", {28'd0, Retired}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc("rstwr.after", 1'b1, 4'd0, O_FETCH_RDY, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global time bound so the bench always ends
  initial begin
    #200000;
    $display("FAIL timeout: got no finish, expected finish");
    $fatal(1);
  end

endmodule
